testeio_mem_data_arbiter: RTL and testbench

TESTEIO_MEM_DATA_ARBITER -- requirements
Module: testeio_mem_data_arbiter

---
 rtl/testeio_mem_data_arbiter_pkg.sv | 19 +
 rtl/testeio_mem_data_arbiter_if.sv | 32 +++
 rtl/testeio_mem_data_arbiter_rr_arb2.sv | 23 ++
 rtl/testeio_mem_data_arbiter.sv | 91 +++++++++
 tb/tb_testeio_mem_data_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/testeio_mem_data_arbiter_pkg.sv
// Shared definitions for the two-requester memory read arbiter:
// width defaults, FSM state codes and the requester index type.
package testeio_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 2;

    // The four transaction phases, kept as plain constants for legacy tools
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    typedef logic req_idx_t;
    localparam req_idx_t REQ0 = 1'b0;
    localparam req_idx_t REQ1 = 1'b1;

endpackage

// File: rtl/testeio_mem_data_arbiter_if.sv
// Request/response and slave-side bus of the arbiter; the slave modport is
// the arbiter's view, the master modport is the requesters' and slave's view.
interface testeio_mem_data_arbiter_if
    import testeio_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              gnt0;
    logic              gnt1;
    logic              rsp_valid0;
    logic              rsp_valid1;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic [ADDR_W-1:0] slv_address;
    logic [DATA_W-1:0] slv_readdata;

    modport slave (
        input  req0, req1, addr0, addr1, slv_readdata,
        output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, busy, slv_address
    );

    modport master (
        output req0, req1, addr0, addr1, slv_readdata,
        input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, busy, slv_address
    );

endinterface

// File: rtl/testeio_mem_data_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that did not win last time.
module testeio_rr_arb2
    import testeio_pkg::*;
(
    input  logic     i_req0,
    input  logic     i_req1,
    input  req_idx_t i_last_winner,
    output req_idx_t o_winner,
    output logic     o_any
);

    always_comb begin
        o_any    = i_req0 | i_req1;
        o_winner = REQ0;
        if (i_req0 && i_req1) begin
            o_winner = (i_last_winner == REQ0) ? REQ1 : REQ0;
        end else if (i_req1) begin
            o_winner = REQ1;
        end
    end

endmodule

// File: rtl/testeio_mem_data_arbiter.sv
// Arbitrates single reads from two requesters onto one registered-read slave;
// each transaction runs IDLE->ADDR->WAIT->RESP with every output registered.
module testeio_mem_data_arbiter
    import testeio_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
)(
    input  logic                         clk,
    input  logic                         reset,
    testeio_mem_data_arbiter_if.slave    bus
);

    state_t            r_state;
    req_idx_t          r_last_winner;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_rsp_valid0;
    logic              r_rsp_valid1;
    logic              r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    req_idx_t          w_winner;
    logic              w_any;

    testeio_rr_arb2 u_rr_arb2 (
        .i_req0        (bus.req0),
        .i_req1        (bus.req1),
        .i_last_winner (r_last_winner),
        .o_winner      (w_winner),
        .o_any         (w_any)
    );

    // r_last_winner doubles as the current transaction's owner once past IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_last_winner <= REQ1;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_rsp_valid0  <= 1'b0;
            r_rsp_valid1  <= 1'b0;
            r_busy        <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state       <= ST_ADDR;
                        r_last_winner <= w_winner;
                        r_addr        <= (w_winner == REQ1) ? bus.addr1 : bus.addr0;
                        r_gnt0        <= (w_winner == REQ0);
                        r_gnt1        <= (w_winner == REQ1);
                        r_busy        <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    r_state <= ST_WAIT;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                end
                ST_WAIT: begin
                    r_state      <= ST_RESP;
                    r_data       <= bus.slv_readdata;
                    r_rsp_valid0 <= (r_last_winner == REQ0);
                    r_rsp_valid1 <= (r_last_winner == REQ1);
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_rsp_valid0 <= 1'b0;
                    r_rsp_valid1 <= 1'b0;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0        = r_gnt0;
    assign bus.gnt1        = r_gnt1;
    assign bus.rsp_valid0  = r_rsp_valid0;
    assign bus.rsp_valid1  = r_rsp_valid1;
    assign bus.rsp_data    = r_data;
    assign bus.busy        = r_busy;
    assign bus.slv_address = r_addr;

endmodule

// File: tb/tb_testeio_mem_data_arbiter.sv
// Bench for the memory read arbiter: directed scenarios plus random requesters,
// every cycle compared against a transaction-level schedule model.
module tb_testeio_mem_data_arbiter;
    import testeio_pkg::*;

    localparam int DW = 32;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic reset;

    testeio_mem_data_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    testeio_mem_data_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Slave with one cycle of read latency
    logic [DW-1:0] mem [4];
    always @(posedge clk) bus.slv_readdata <= mem[bus.slv_address];

    int testsRun    = 0;
    int testsFailed = 0;

    // Model: a transaction accepted at cycle txStart grants then, responds two
    // cycles later and frees the arbiter four cycles after acceptance.
    int            cyc;
    bit            active;
    int            txStart;
    int            txWinner;
    int            lastWinner;
    logic [AW-1:0] txAddr;
    logic [DW-1:0] txData;
    logic [AW-1:0] holdAddr;
    logic [DW-1:0] holdData;

    task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task modelReset();
        active     = 1'b0;
        lastWinner = 1;
        holdAddr   = '0;
        holdData   = '0;
    endtask

    task modelEdge();
        cyc++;
        if ((!active || cyc >= txStart + 4) && (bus.req0 || bus.req1)) begin
            if (bus.req0 && bus.req1) txWinner = 1 - lastWinner;
            else                      txWinner = bus.req1 ? 1 : 0;
            lastWinner = txWinner;
            txAddr     = (txWinner == 1) ? bus.addr1 : bus.addr0;
            txData     = mem[txAddr];
            txStart    = cyc;
            active     = 1'b1;
            holdAddr   = txAddr;
        end
        if (active && cyc == txStart + 2) holdData = txData;
    endtask

    task checkCycle();
        bit grantNow, respNow, busyNow;
        grantNow = active && (cyc == txStart);
        respNow  = active && (cyc == txStart + 2);
        busyNow  = active && (cyc <= txStart + 2);
        checkOutput("gnt0",        32'(bus.gnt0),        32'(grantNow && txWinner == 0));
        checkOutput("gnt1",        32'(bus.gnt1),        32'(grantNow && txWinner == 1));
        checkOutput("rsp_valid0",  32'(bus.rsp_valid0),  32'(respNow && txWinner == 0));
        checkOutput("rsp_valid1",  32'(bus.rsp_valid1),  32'(respNow && txWinner == 1));
        checkOutput("busy",        32'(bus.busy),        32'(busyNow));
        checkOutput("slv_address", 32'(bus.slv_address), 32'(holdAddr));
        checkOutput("rsp_data",    bus.rsp_data,         holdData);
    endtask

    task stepCycle();
        @(posedge clk);
        if (!reset) modelEdge();
        @(negedge clk);
        checkCycle();
    endtask

    task applyStimulus(input logic r0, input logic r1, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.req0  = r0;
        bus.req1  = r1;
        bus.addr0 = a0;
        bus.addr1 = a1;
    endtask

    task runIdle(input int n);
        applyStimulus(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task doReset();
        reset = 1'b1;
        #1;
        modelReset();
        checkCycle();
        stepCycle();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int grants, expAlt, gnt0Count;
        bit r0, r1;
        logic [AW-1:0] a0, a1;

        cyc = 0;
        txStart = 0;
        txWinner = 0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        applyStimulus(1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        #1 reset = 1'b1;
        modelReset();
        @(negedge clk);
        checkCycle();
        stepCycle();
        reset = 1'b0;

        // Single request from requester 0
        mem[0] = 32'h0000_00A5;
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0);
        stepCycle();
        checkOutput("t1_gnt0", 32'(bus.gnt0), 32'd1);
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0);
        stepCycle();
        checkOutput("t1_busy_wait", 32'(bus.busy), 32'd1);
        stepCycle();
        checkOutput("t1_rsp_valid0", 32'(bus.rsp_valid0), 32'd1);
        checkOutput("t1_rsp_data", bus.rsp_data, 32'h0000_00A5);
        stepCycle();
        checkOutput("t1_busy_idle", 32'(bus.busy), 32'd0);

        // Continuous tie right after reset alternates 0,1,0,1
        doReset();
        mem[1] = 32'h11;
        mem[3] = 32'h33;
        applyStimulus(1'b1, 1'b1, 2'd1, 2'd3);
        grants = 0;
        expAlt = 0;
        for (int i = 0; i < 16; i++) begin
            stepCycle();
            if (bus.gnt0 || bus.gnt1) begin
                checkOutput("t2_gnt_order", 32'(bus.gnt1), 32'(expAlt));
                expAlt = 1 - expAlt;
                grants++;
            end
        end
        checkOutput("t2_grant_count", 32'(grants), 32'd4);
        runIdle(4);

        // Address change during ADDR is ignored
        mem[0] = 32'h5A5A_5A5A;
        mem[2] = 32'h0;
        applyStimulus(1'b0, 1'b1, 2'd0, 2'd2);
        stepCycle();
        checkOutput("t3_addr_in_addr", 32'(bus.slv_address), 32'd2);
        applyStimulus(1'b0, 1'b1, 2'd0, 2'd0);
        stepCycle();
        checkOutput("t3_addr_in_wait", 32'(bus.slv_address), 32'd2);
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0);
        stepCycle();
        checkOutput("t3_rsp_valid1", 32'(bus.rsp_valid1), 32'd1);
        checkOutput("t3_rsp_data", bus.rsp_data, 32'h0);
        runIdle(2);

        // Request pulsed only during WAIT is never granted
        mem[1] = 32'h77;
        applyStimulus(1'b0, 1'b1, 2'd0, 2'd1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd1);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd1);
        gnt0Count = 0;
        stepCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            if (bus.gnt0) gnt0Count++;
            stepCycle();
        end
        checkOutput("t4_no_gnt0", 32'(gnt0Count), 32'd0);
        checkOutput("t4_idle", 32'(bus.busy), 32'd0);

        // Reset during WAIT aborts the transaction; next tie goes to requester 0
        mem[3] = 32'h99;
        applyStimulus(1'b1, 1'b0, 2'd3, 2'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0);
        stepCycle();
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("t5_busy", 32'(bus.busy), 32'd0);
        checkOutput("t5_slv_address", 32'(bus.slv_address), 32'd0);
        checkOutput("t5_rsp_data", bus.rsp_data, 32'd0);
        checkOutput("t5_rsp_valid0", 32'(bus.rsp_valid0), 32'd0);
        stepCycle();
        stepCycle();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'd1, 2'd2);
        stepCycle();
        checkOutput("t5_tie_gnt0", 32'(bus.gnt0), 32'd1);
        runIdle(4);

        // Back-to-back reads: rsp_data holds until the second capture
        mem[1] = 32'h12;
        mem[2] = 32'h34;
        applyStimulus(1'b1, 1'b0, 2'd1, 2'd0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 2'd2, 2'd0);
        stepCycle();
        stepCycle();
        checkOutput("t6_first_data", bus.rsp_data, 32'h12);
        stepCycle();
        stepCycle();
        checkOutput("t6_second_gnt0", 32'(bus.gnt0), 32'd1);
        checkOutput("t6_hold_at_gnt", bus.rsp_data, 32'h12);
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0);
        stepCycle();
        checkOutput("t6_hold_at_wait", bus.rsp_data, 32'h12);
        stepCycle();
        checkOutput("t6_second_data", bus.rsp_data, 32'h34);
        runIdle(2);

        // Random requesters that drop req on their grant
        for (int i = 0; i < 4; i++) mem[i] = $urandom();
        r0 = 1'b0;
        r1 = 1'b0;
        a0 = '0;
        a1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (bus.gnt0)                          r0 = 1'b0;
            else if (!r0 && $urandom_range(0, 2) == 0) begin r0 = 1'b1; a0 = AW'($urandom()); end
            else if (r0 && $urandom_range(0, 3) == 0)  a0 = AW'($urandom());
            if (bus.gnt1)                          r1 = 1'b0;
            else if (!r1 && $urandom_range(0, 2) == 0) begin r1 = 1'b1; a1 = AW'($urandom()); end
            else if (r1 && $urandom_range(0, 3) == 0)  a1 = AW'($urandom());
            applyStimulus(r0, r1, a0, a1);
            stepCycle();
        end
        runIdle(4);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
